// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared opcodes, FSM states and instruction field positions
package regfile_seq_pkg;

    localparam int INSTR_W = 12;
    localparam int OP_HI   = 11;
    localparam int OP_LO   = 9;
    localparam int RD_HI   = 8;
    localparam int RD_LO   = 6;
    localparam int RP_HI   = 5;
    localparam int RP_LO   = 3;
    localparam int RQ_HI   = 2;
    localparam int RQ_LO   = 0;
    localparam int IMM_HI  = 3;
    localparam int IMM_LO  = 0;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LDI = 3'd1,
        OP_MOV = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_AND = 3'd5,
        OP_OR  = 3'd6,
        OP_OUT = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    function automatic logic op_writes(input op_e op);
        return (op != OP_NOP) && (op != OP_OUT);
    endfunction

endpackage

// File: rtl/regfile_seq_ctrl_if.sv
// rtl/regfile_seq_ctrl_if.sv - instruction handshake and register file port bundle
interface regfile_seq_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
);
    import regfile_seq_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [ADDR_W-1:0]  rp;
    logic [ADDR_W-1:0]  rq;
    logic [DATA_W-1:0]  datap;
    logic [DATA_W-1:0]  dataq;
    logic [ADDR_W-1:0]  wa;
    logic [DATA_W-1:0]  ld_data;
    logic               wr;
    logic [DATA_W-1:0]  result;
    logic               flag_z;
    logic               flag_c;
    logic               done;

    // Instruction source plus register file side
    modport master (
        output instr, instr_valid, datap, dataq,
        input  instr_ready, rp, rq, wa, ld_data, wr, result, flag_z, flag_c, done
    );

    // Sequencer side
    modport slave (
        input  instr, instr_valid, datap, dataq,
        output instr_ready, rp, rq, wa, ld_data, wr, result, flag_z, flag_c, done
    );

endinterface

// File: rtl/regfile_seq_ctrl_alu4.sv
// rtl/regfile_seq_ctrl_alu4.sv - combinational ALU for the register file sequencer
module alu4
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  op_e              op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] y_o,
    output logic              c_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        y_o = '0;
        c_o = 1'b0;
        case (op_i)
            OP_LDI: y_o = imm_i;
            OP_MOV: y_o = a_i;
            OP_ADD: begin
                y_o = sum[DATA_W-1:0];
                c_o = sum[DATA_W];
            end
            // Borrow out of the extended subtraction is exactly a < b unsigned
            OP_SUB: begin
                y_o = diff[DATA_W-1:0];
                c_o = diff[DATA_W];
            end
            OP_AND: y_o = a_i & b_i;
            OP_OR:  y_o = a_i | b_i;
            OP_OUT: y_o = a_i;
            default: begin
                y_o = '0;
                c_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// rtl/regfile_seq_ctrl.sv - four-phase micro-instruction sequencer for the 8x4 register file
module regfile_seq_ctrl
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
) (
    input logic               clk_i,
    input logic               rst_i,
    regfile_seq_ctrl_if.slave bus
);

    state_e             state_q;
    logic [INSTR_W-1:0] ir_q;
    logic [DATA_W-1:0]  opp_q;
    logic [DATA_W-1:0]  opq_q;
    logic [ADDR_W-1:0]  rp_q;
    logic [ADDR_W-1:0]  rq_q;
    logic [ADDR_W-1:0]  wa_q;
    logic [DATA_W-1:0]  ld_data_q;
    logic               wr_q;
    logic [DATA_W-1:0]  result_q;
    logic               flag_z_q;
    logic               flag_c_q;
    logic               done_q;
    logic               ready_q;

    op_e                ir_op;
    logic [DATA_W-1:0]  alu_y;
    logic               alu_c;

    assign ir_op = op_e'(ir_q[OP_HI:OP_LO]);

    alu4 #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i  (ir_op),
        .a_i   (opp_q),
        .b_i   (opq_q),
        .imm_i (ir_q[IMM_HI:IMM_LO]),
        .y_o   (alu_y),
        .c_o   (alu_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            opp_q     <= '0;
            opq_q     <= '0;
            rp_q      <= '0;
            rq_q      <= '0;
            wa_q      <= '0;
            ld_data_q <= '0;
            wr_q      <= 1'b0;
            result_q  <= '0;
            flag_z_q  <= 1'b1;
            flag_c_q  <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Read selects are loaded here so they are stable for all of READ
                    if (bus.instr_valid && ready_q) begin
                        ir_q    <= bus.instr;
                        rp_q    <= bus.instr[RP_HI:RP_LO];
                        rq_q    <= bus.instr[RQ_HI:RQ_LO];
                        ready_q <= 1'b0;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    opp_q   <= bus.datap;
                    opq_q   <= bus.dataq;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (ir_op != OP_NOP) begin
                        result_q <= alu_y;
                        flag_z_q <= (alu_y == '0);
                        flag_c_q <= alu_c;
                    end
                    // NOP keeps RESULT, so write data mirrors the held value
                    wa_q      <= ir_q[RD_HI:RD_LO];
                    ld_data_q <= (ir_op == OP_NOP) ? result_q : alu_y;
                    wr_q      <= op_writes(ir_op);
                    done_q    <= 1'b1;
                    state_q   <= S_WRITE;
                end
                S_WRITE: begin
                    wr_q    <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    wr_q    <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.rp          = rp_q;
    assign bus.rq          = rq_q;
    assign bus.wa          = wa_q;
    assign bus.ld_data     = ld_data_q;
    assign bus.wr          = wr_q;
    assign bus.result      = result_q;
    assign bus.flag_z      = flag_z_q;
    assign bus.flag_c      = flag_c_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb/tb_regfile_seq_ctrl.sv - directed bench for regfile_seq_ctrl with a register file model
module tb_regfile_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_seq_ctrl_if #(.DATA_W(4), .ADDR_W(3)) bus ();

    regfile_seq_ctrl #(.DATA_W(4), .ADDR_W(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] rf [8];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int last_done = 0;
    int prev_done = 0;

    assign bus.datap = rf[bus.rp];
    assign bus.dataq = rf[bus.rq];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.wr) begin
            rf[bus.wa] <= bus.ld_data;
            wr_cnt = wr_cnt + 1;
        end
        if (bus.done) begin
            done_cnt  = done_cnt + 1;
            prev_done = last_done;
            last_done = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; ends at the negedge of the IDLE cycle after WRITE
    task automatic run(input string tag, input logic [11:0] i,
                       input logic [2:0] e_rp, input logic [2:0] e_rq,
                       input logic e_wr, input logic [2:0] e_wa, input logic [3:0] e_ld,
                       input logic [3:0] e_res, input logic e_z, input logic e_c);
        int n = 0;
        bus.instr       = i;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, bus.instr_ready, 1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk({tag, "_rp"}, bus.rp, e_rp);
        chk({tag, "_rq"}, bus.rq, e_rq);
        chk({tag, "_busy"}, bus.instr_ready, 0);
        @(negedge clk);
        chk({tag, "_exec_wr"}, bus.wr, 0);
        @(negedge clk);
        chk({tag, "_wr"}, bus.wr, e_wr);
        chk({tag, "_wa"}, bus.wa, e_wa);
        chk({tag, "_ld"}, bus.ld_data, e_ld);
        chk({tag, "_done"}, bus.done, 1);
        @(negedge clk);
        chk({tag, "_done_off"}, bus.done, 0);
        chk({tag, "_wr_off"}, bus.wr, 0);
        chk({tag, "_ready"}, bus.instr_ready, 1);
        chk({tag, "_res"}, bus.result, e_res);
        chk({tag, "_z"}, bus.flag_z, e_z);
        chk({tag, "_c"}, bus.flag_c, e_c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        int dc;
        for (int k = 0; k < 8; k++) rf[k] = 4'h0;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_wr", bus.wr, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_z", bus.flag_z, 1);
        chk("rst_c", bus.flag_c, 0);
        chk("rst_rp", bus.rp, 0);
        chk("rst_wa", bus.wa, 0);
        chk("rst_ld", bus.ld_data, 0);

        run("ldi_r1", 12'h245, 3'd0, 3'd5, 1, 3'd1, 4'h5, 4'h5, 0, 0);
        run("ldi_r2", 12'h283, 3'd0, 3'd3, 1, 3'd2, 4'h3, 4'h3, 0, 0);
        chk("spacing", last_done - prev_done, 4);
        chk("rf1", rf[1], 4'h5);
        chk("rf2", rf[2], 4'h3);

        run("add_r3", 12'h6CA, 3'd1, 3'd2, 1, 3'd3, 4'h8, 4'h8, 0, 0);
        chk("rf3", rf[3], 4'h8);
        wc = wr_cnt;
        run("out_r3", 12'hE18, 3'd3, 3'd0, 0, 3'd0, 4'h8, 4'h8, 0, 0);
        chk("out_nowrite", wr_cnt, wc);

        run("sub_r4", 12'h911, 3'd2, 3'd1, 1, 3'd4, 4'hE, 4'hE, 0, 1);
        run("ldi_r5", 12'h34F, 3'd1, 3'd7, 1, 3'd5, 4'hF, 4'hF, 0, 0);
        run("ldi_r7", 12'h3C1, 3'd0, 3'd1, 1, 3'd7, 4'h1, 4'h1, 0, 0);
        run("add_r6", 12'h7AF, 3'd5, 3'd7, 1, 3'd6, 4'h0, 4'h0, 1, 1);
        chk("rf4", rf[4], 4'hE);
        chk("rf6", rf[6], 4'h0);

        // Second instruction offered while the first is still in flight
        dc = done_cnt;
        bus.instr       = 12'h209;
        bus.instr_valid = 1'b1;
        chk("hold_ready_idle", bus.instr_ready, 1);
        @(negedge clk);
        bus.instr = 12'h480;
        chk("hold_ready_read", bus.instr_ready, 0);
        chk("hold_rp", bus.rp, 1);
        @(negedge clk);
        chk("hold_ready_exec", bus.instr_ready, 0);
        @(negedge clk);
        chk("hold_ready_write", bus.instr_ready, 0);
        chk("hold_a_wr", bus.wr, 1);
        chk("hold_a_wa", bus.wa, 0);
        chk("hold_a_ld", bus.ld_data, 4'h9);
        run("hold_b", 12'h480, 3'd0, 3'd0, 1, 3'd2, 4'h9, 4'h9, 0, 0);
        chk("hold_rf0", rf[0], 4'h9);
        chk("hold_rf2", rf[2], 4'h9);
        chk("hold_done_cnt", done_cnt, dc + 2);
        repeat (6) @(negedge clk);
        chk("hold_no_dup", done_cnt, dc + 2);

        // Reset while ADD r3,r1,r2 (5+9) is in EXEC
        bus.instr       = 12'h6CA;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        wc = wr_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", bus.instr_ready, 1);
        chk("abort_wr", bus.wr, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_result", bus.result, 0);
        chk("abort_z", bus.flag_z, 1);
        chk("abort_c", bus.flag_c, 0);
        repeat (4) @(negedge clk);
        chk("abort_nowrite", wr_cnt, wc);
        chk("abort_rf3", rf[3], 4'h8);

        run("self_add", 12'h649, 3'd1, 3'd1, 1, 3'd1, 4'hA, 4'hA, 0, 0);
        chk("self_rf1", rf[1], 4'hA);
        run("mov_r2", 12'h488, 3'd1, 3'd0, 1, 3'd2, 4'hA, 4'hA, 0, 0);
        chk("mov_rf2", rf[2], 4'hA);
        wc = wr_cnt;
        run("nop", 12'h000, 3'd0, 3'd0, 0, 3'd0, 4'hA, 4'hA, 0, 0);
        chk("nop_nowrite", wr_cnt, wc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
